gir_wb_ctrl: RTL
================

Name: gir_wb_ctrl

Overview:
Write-side controller for the general integer register file. It arbitrates results from the ALU and LSU producers and drives the register-file write port (rd, rd_wen, x_rd) from one registered writeback stage. It also keeps a 32-entry busy scoreboard so the issue stage can stall on RAW/WAW hazards until a destination register has been written.

Parameters:
XLEN, 64, data width of integer registers and producer results
CNT_W, 6, width of outstanding-write counter (holds 0..32)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
iss_valid  in  1  issue stage presents an instruction
iss_wen  in  1  instruction writes a destination register
iss_rd  in  5  destination register index
iss_rs1  in  5  source 1 index, for hazard check
iss_rs2  in  5  source 2 index, for hazard check
iss_ready  out  1  issue may proceed this cycle
alu_valid  in  1  ALU result valid
alu_ready  out  1  ALU result accepted
alu_rd  in  5  ALU destination
alu_data  in  XLEN  ALU result
lsu_valid  in  1  LSU load result valid
lsu_ready  out  1  LSU result accepted
lsu_rd  in  5  LSU destination
lsu_data  in  XLEN  LSU result
rd  out  5  register-file write index
rd_wen  out  1  register-file write enable
x_rd  out  XLEN  register-file write data
outstanding  out  CNT_W  number of busy registers
idle  out  1  outstanding==0 and no write in flight
wb_err  out  1  sticky: write to a non-busy nonzero register

Behaviour:
- Reset (rst=0, asynchronous): busy[31:0]=0, stage valid=0, rd=0, rd_wen=0, x_rd=0, outstanding=0, wb_err=0. Reset mid-operation discards any in-flight write and all busy state.
- Hazard, combinational:
  - haz = busy[iss_rs1] | busy[iss_rs2] | (iss_wen & busy[iss_rd]).
  - busy[0] is hard-wired 0.
  - iss_ready = ~haz.
- Issue acceptance: when iss_valid & iss_ready & iss_wen & iss_rd!=0, set busy[iss_rd] at the clock edge and increment outstanding.
- Arbitration, fixed priority, LSU over ALU:
  - lsu_ready = 1.
  - alu_ready = ~lsu_valid.
  - Each handshake occurs when valid & ready. At most one accepted per cycle.
- Writeback stage, one register:
  - A result accepted in cycle N appears as rd_wen=1, rd, x_rd in cycle N+1.
  - The register file writes at the end of N+1.
  - busy[rd] clears at the same edge and outstanding decrements.
  - Sources read in N+2 therefore see the new value. There is no bypass.
- x0 handling: an accepted result with rd=0 is consumed (ready asserted) but produces rd_wen=0 and no busy/counter change.
- Error: an accepted result with rd!=0 and busy[rd]=0 sets wb_err (sticky until reset). The write is still performed and the counter is not decremented.
- Simultaneous set/clear on the same register in one cycle: the issue stalls, because busy is still 1 that cycle. Set and clear never coincide.
- Simultaneous issue of a different rd and clear in one cycle: outstanding is unchanged (+1-1).
- Counter never wraps: maximum 31, because x0 is excluded.
- idle = (outstanding==0) & ~rd_wen.
- When no result is accepted, rd_wen=0 and rd/x_rd hold their previous values.

Decomposition:
- Shared package/header: XLEN, REG_IDX_W=5, NREGS=32, and zero-register index constant.
- Sub-module gir_scoreboard: busy vector, set/clear ports, two read lookups plus a WAW lookup, outstanding counter.
- Arbitration and the writeback stage stay in gir_wb_ctrl.

Test Plan:
- Reset: hold rst=0 three cycles with random inputs -> rd_wen=0, outstanding=0, iss_ready=1, wb_err=0. Release reset -> idle=1.
- Basic write: issue rd=5, then alu_valid rd=5 data=0x1234 two cycles later -> rd_wen=1, rd=5, x_rd=0x1234 one cycle after accept. busy[5] clears. Issue with rs1=5 stalls until that edge, then iss_ready=1.
- Contention: lsu_valid rd=3 and alu_valid rd=7 in the same cycle (both busy) -> lsu accepted, alu_ready=0. Next cycle alu accepted. Writes rd=3, then rd=7 on consecutive cycles; outstanding goes 2→1→0.
- WAW stall: issue rd=9; issue again rd=9 before writeback -> iss_ready=0 until busy[9] clears.
- x0: issue rd=0 and alu result rd=0 data=0xFFFF -> no busy set, alu_ready=1, rd_wen=0, outstanding=0.
- Error and reset mid-flight: alu result rd=12 with busy[12]=0 -> wb_err=1, write occurs. Then issue rd=4 and assert rst during its pending result -> all busy cleared, wb_err=0, no write after reset.

Source files
------------

// File: rtl/gir_wb_ctrl_pkg.sv
// Shared constants and payload types for the integer register-file writeback controller.
package gir_wb_ctrl_pkg;
    localparam int unsigned XLEN      = 64;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned NREGS     = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      xdata_t;

    localparam reg_idx_t ZERO_REG = '0;

    typedef struct packed {
        reg_idx_t rd;
        xdata_t   data;
    } wb_req_t;
endpackage

// File: rtl/gir_wb_ctrl_if.sv
// Issue, producer and register-file write port bundle of the writeback controller.
interface gir_wb_ctrl_if;
    import gir_wb_ctrl_pkg::*;

    logic             iss_valid;
    logic             iss_wen;
    reg_idx_t         iss_rd;
    reg_idx_t         iss_rs1;
    reg_idx_t         iss_rs2;
    logic             iss_ready;
    logic             alu_valid;
    logic             alu_ready;
    reg_idx_t         alu_rd;
    xdata_t           alu_data;
    logic             lsu_valid;
    logic             lsu_ready;
    reg_idx_t         lsu_rd;
    xdata_t           lsu_data;
    reg_idx_t         rd;
    logic             rd_wen;
    xdata_t           x_rd;
    logic [CNT_W-1:0] outstanding;
    logic             idle;
    logic             wb_err;

    modport slave (
        input  iss_valid, iss_wen, iss_rd, iss_rs1, iss_rs2,
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output iss_ready, alu_ready, lsu_ready,
        output rd, rd_wen, x_rd, outstanding, idle, wb_err
    );

    modport master (
        output iss_valid, iss_wen, iss_rd, iss_rs1, iss_rs2,
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  iss_ready, alu_ready, lsu_ready,
        input  rd, rd_wen, x_rd, outstanding, idle, wb_err
    );
endinterface

// File: rtl/gir_scoreboard.sv
// Busy-register scoreboard: per-register pending-write flags plus a count of busy registers.
module gir_scoreboard
    import gir_wb_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  reg_idx_t         set_idx,
    input  logic             clr_en,
    input  reg_idx_t         clr_idx,
    input  reg_idx_t         rs1_idx,
    input  reg_idx_t         rs2_idx,
    input  reg_idx_t         rd_idx,
    output logic             rs1_busy,
    output logic             rs2_busy,
    output logic             rd_busy,
    output logic             clr_busy,
    output logic [CNT_W-1:0] outstanding
);
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic             set_hit;
    logic             clr_hit;

    assign rs1_busy = busy[rs1_idx];
    assign rs2_busy = busy[rs2_idx];
    assign rd_busy  = busy[rd_idx];
    assign clr_busy = busy[clr_idx];

    // A clear of a register that is not busy is ignored so the count stays exact.
    assign set_hit = set_en && (set_idx != ZERO_REG);
    assign clr_hit = clr_en && busy[clr_idx];

    always_comb begin
        busy_nxt = busy;
        if (clr_hit) busy_nxt[clr_idx] = 1'b0;
        if (set_hit) busy_nxt[set_idx] = 1'b1;
        busy_nxt[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= '0;
            outstanding <= '0;
        end else begin
            busy        <= busy_nxt;
            outstanding <= outstanding + CNT_W'(set_hit) - CNT_W'(clr_hit);
        end
    end
endmodule

// File: rtl/gir_wb_ctrl.sv
// Integer register-file write controller: LSU-over-ALU arbitration, one registered
// writeback stage, and a busy scoreboard for issue-side RAW/WAW stalls.
module gir_wb_ctrl
    import gir_wb_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    gir_wb_ctrl_if.slave  bus
);
    logic             rs1_busy;
    logic             rs2_busy;
    logic             rd_busy;
    logic             clr_busy;
    logic             haz;
    logic             iss_fire;
    logic             lsu_fire;
    logic             alu_fire;
    logic             acc_write;
    wb_req_t          sel;
    reg_idx_t         wb_rd;
    xdata_t           wb_data;
    logic             wb_wen;
    logic             wb_err_q;
    logic [CNT_W-1:0] outstanding;

    assign haz           = rs1_busy | rs2_busy | (bus.iss_wen & rd_busy);
    assign bus.iss_ready = ~haz;
    assign iss_fire      = bus.iss_valid & ~haz & bus.iss_wen;

    assign bus.lsu_ready = 1'b1;
    assign bus.alu_ready = ~bus.lsu_valid;
    assign lsu_fire      = bus.lsu_valid;
    assign alu_fire      = bus.alu_valid & ~bus.lsu_valid;

    always_comb begin
        sel.rd   = bus.alu_rd;
        sel.data = bus.alu_data;
        if (lsu_fire) begin
            sel.rd   = bus.lsu_rd;
            sel.data = bus.lsu_data;
        end
    end

    // Results to x0 are consumed but never reach the register file.
    assign acc_write = (lsu_fire | alu_fire) && (sel.rd != ZERO_REG);

    gir_scoreboard u_scoreboard (
        .clk         (clk),
        .rst_n       (rst),
        .set_en      (iss_fire),
        .set_idx     (bus.iss_rd),
        .clr_en      (wb_wen),
        .clr_idx     (wb_rd),
        .rs1_idx     (bus.iss_rs1),
        .rs2_idx     (bus.iss_rs2),
        .rd_idx      (bus.iss_rd),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .rd_busy     (rd_busy),
        .clr_busy    (clr_busy),
        .outstanding (outstanding)
    );

    // Writeback stage; the error flags a write retiring to a register nobody reserved.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_wen   <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            wb_err_q <= 1'b0;
        end else begin
            wb_wen <= acc_write;
            if (acc_write) begin
                wb_rd   <= sel.rd;
                wb_data <= sel.data;
            end
            if (wb_wen && !clr_busy) wb_err_q <= 1'b1;
        end
    end

    assign bus.rd          = wb_rd;
    assign bus.rd_wen      = wb_wen;
    assign bus.x_rd        = wb_data;
    assign bus.wb_err      = wb_err_q;
    assign bus.outstanding = outstanding;
    assign bus.idle        = (outstanding == '0) & ~wb_wen;
endmodule
